// File: rtl/conv_collector_pkg.sv
// Shared CNN definitions: collector FSM encoding, default map/word sizes.
// Also holds the address-width helper used by the collector and its RAM.
package conv_collector_pkg;

    localparam int CNN_DW      = 32;
    localparam int CNN_OUT_DIM = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } coll_state_t;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_collector_if.sv
// Capture and read-port bundle between convolver/reader and collector.
// master drives pixels and read requests; slave returns read data.
interface conv_collector_if
    import conv_collector_pkg::*;
#(
    parameter int DW      = CNN_DW,
    parameter int OUT_DIM = CNN_OUT_DIM
);
    localparam int AW = addr_w(OUT_DIM * OUT_DIM);

    logic          ce;
    logic [DW-1:0] conv_op;
    logic          valid_conv;
    logic          end_conv;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    modport master (
        output ce, conv_op, valid_conv, end_conv,
        output rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  ce, conv_op, valid_conv, end_conv,
        input  rd_en, rd_addr,
        output rd_data, rd_valid
    );

endinterface

// File: rtl/conv_out_ram.sv
// Output-map buffer: one write port, one registered read port.
// Reads return pre-write contents; out-of-range reads return zero.
module conv_out_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    output logic          rvalid
);

    logic [DW-1:0] mem [DEPTH];

    // storage write; contents deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // registered read with range guard and one-cycle valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                if (32'(raddr) < DEPTH) begin
                    rdata <= mem[raddr];
                end else begin
                    rdata <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/conv_collector.sv
// Collects convolver output pixels into a raster-order buffer.
// Tracks frame completion plus sticky overflow / short-frame flags.
module conv_collector
    import conv_collector_pkg::*;
#(
    parameter int OUT_DIM = CNN_OUT_DIM,
    parameter int DW      = CNN_DW,
    parameter int RELU    = 0,
    localparam int N      = OUT_DIM * OUT_DIM,
    localparam int AW     = addr_w(N),
    localparam int CW     = AW + 1
) (
    input  logic          clk,
    input  logic          global_rst_n,
    input  logic          clear,
    conv_collector_if.slave bus,
    output logic [CW-1:0] wr_count,
    output logic          frame_done,
    output logic          overflow,
    output logic          short_frame
);

    localparam logic [CW-1:0] FULL = CW'(N);

    coll_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          short_q, short_d;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [CW-1:0] base;
    logic [CW-1:0] cnt_inc;
    logic          full;

    // optional ReLU clamp on the captured word
    always_comb begin
        wdata = bus.conv_op;
        if (RELU != 0 && bus.conv_op[DW-1]) begin
            wdata = '0;
        end
    end

    // next-state, counter, flags and write strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        short_d = short_q;
        we      = 1'b0;
        waddr   = '0;
        full    = (cnt_q == FULL);
        unique case (state_q)
            COLLECT: base = cnt_q;
            default: base = '0;
        endcase
        cnt_inc = base + 1'b1;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            short_d = 1'b0;
        end else if (bus.ce) begin
            if (bus.valid_conv) begin
                if (state_q == DONE && full) begin
                    ovf_d = 1'b1;
                end else begin
                    we    = 1'b1;
                    waddr = base[AW-1:0];
                    cnt_d = cnt_inc;
                    if (bus.end_conv || cnt_inc == FULL) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        if (cnt_inc != FULL) begin
                            short_d = 1'b1;
                        end
                    end else begin
                        state_d = COLLECT;
                        done_d  = 1'b0;
                    end
                end
            end else if (bus.end_conv) begin
                state_d = DONE;
                done_d  = 1'b1;
                if (!full) begin
                    short_d = 1'b1;
                end
            end
        end
    end

    // state and status registers
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            short_q <= short_d;
        end
    end

    assign wr_count    = cnt_q;
    assign frame_done  = done_q;
    assign overflow    = ovf_q;
    assign short_frame = short_q;

    conv_out_ram #(
        .DW    (DW),
        .DEPTH (N),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .rst_n  (global_rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re     (bus.rd_en),
        .raddr  (bus.rd_addr),
        .rdata  (bus.rd_data),
        .rvalid (bus.rd_valid)
    );

endmodule
